gpu_cmd_packet_writer: RTL and testbench
========================================

// Module: gpu_cmd_packet_writer
// PURPOSE
//  Transmit side of the GP0 command-FIFO word protocol consumed by the GPU parser/vertex loader.
//  Takes one primitive description (command byte + per-vertex XY/RGB/UV + CLUT/TPAGE/size) latched on a start pulse.
//  Serialises it into the exact 32-bit GP0 word sequence over a valid/ready stream.
//  Used by the GTE/DMA bring-up path and by GPU testbenches as a packet source.
// PARAMETERS
//  none
// PORTS
//  i_clk        in   1    clock; single clock domain
//  i_nrst       in   1    asynchronous active-low reset
//  i_start      in   1    pulse: latch all i_* fields below and begin packet; honoured only when o_busy=0
//  i_command    in   8    GP0 command byte
//  i_vtxX       in   44   4x11-bit signed X, vertex n at [11n+10:11n]
//  i_vtxY       in   44   4x11-bit signed Y, same packing
//  i_vtxRGB     in   96   4x24-bit {B,G,R}, vertex n at [24n+23:24n]
//  i_vtxUV      in   64   4x16-bit {V,U}, vertex n at [16n+15:16n]
//  i_clut       in   16   CLUT field (upper half of UV word 0)
//  i_tpage      in   16   texpage field (upper half of UV word 1)
//  i_width      in   10   rect/fill width
//  i_height     in   9    rect/fill height
//  o_validData  out  1    o_data valid
//  o_data       out  32   GP0 word
//  i_ready      in   1    sink accepts word this cycle (FIFO not full)
//  o_busy       out  1    packet in progress
//  o_done       out  1    1-cycle pulse after last word accepted
//  o_error      out  1    1-cycle pulse: unsupported command, nothing emitted
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, latched fields cleared. Reset mid-packet aborts; no further words.
//  Decode (from latched command):
//   - POLY cmd[7:5]=001: gouraud=cmd[4], quad=cmd[3] (nv=4 else 3), tex=cmd[2].
//   - RECT cmd[7:5]=011: size=cmd[4:3] (0=var, 1=1x1, 2=8x8, 3=16x16), tex=cmd[2].
//   - FILL cmd==8'h02.
//   - Anything else: o_error pulse the cycle after start, back to IDLE, o_busy stays 0.
//  Word formats:
//   - CMD = {cmd, B0, G0, R0}.
//   - COLn = {8'h00, Bn, Gn, Rn}.
//   - XYn = {5'd0, Yn, 5'd0, Xn}.
//   - UV0 = {clut, V0, U0}; UV1 = {tpage, V1, U1}; UVn (n>=2) = {16'd0, Vn, Un}.
//   - SIZE = {7'd0, height, 6'd0, width}.
//  Sequences:
//   - POLY: CMD, then for v=0..nv-1: [COLv if gouraud & v>0], XYv, [UVv if tex].
//     Words = 1 + nv*(1+tex) + gouraud*(nv-1).
//   - RECT: CMD, XY0, [UV0 if tex], [SIZE if size==0].
//   - FILL: CMD, XY0, SIZE.
//  FSM:
//   - States IDLE -> CMD -> {COL, XY, UV, SIZE} -> DONE -> IDLE; 2-bit vertex counter advances after XY/UV.
//   - Next state is computed combinationally from decode flags and the vertex counter.
//  Handshake:
//   - o_validData rises the cycle after an accepted i_start.
//   - o_data is held stable while o_validData=1 & i_ready=0.
//   - A word transfers when o_validData & i_ready; the next word is presented the following cycle.
//   - Sustained i_ready=1 gives 1 word/cycle with no bubbles.
//  o_busy: 1 from the cycle after start through the last transfer. o_done pulses the cycle after the last transfer.
//  i_start while o_busy=1 is ignored. Latched fields are never updated mid-packet.
//  Simultaneous o_done and a new i_start: start is ignored (o_busy still 1 that cycle).
//  Reset asserted during stall: o_validData drops immediately (async).
// TESTING
//  - 0x20, X0..2=(10,20),(30,40),(-5,7), RGB0=FF0080 -> 4 words: 20FF0080-equivalent CMD, XY0=0014000A, XY1, XY2=0007_07FB; o_done once.
//  - 0x3C gouraud textured quad -> 12 words in order CMD,XY0,UV0,COL1,XY1,UV1,...; UV0 high=clut, UV1 high=tpage.
//  - 0x64 tex var rect, w=100, h=50 -> 4 words; last = 0x00320064.
//  - 0x68 1x1 sprite -> 2 words. 0x02 fill (w=0x3F0, h=0x1FF) -> 3 words, last 0x01FF03F0.
//  - Random i_ready backpressure on 0x3C -> identical word stream, o_data stable during stalls; i_start mid-packet ignored.
//  - 0xE1 -> o_error pulse, zero words; i_nrst low mid-packet -> o_validData/o_busy 0 immediately, clean next packet.

Source files
------------

// File: rtl/gpu_cmd_packet_writer.sv
// GP0 command packet source: latches one primitive description on i_start and
// streams its 32-bit GP0 words over a valid/ready interface.
module gpu_cmd_packet_writer (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_start,
  input  logic [7:0]  i_command,
  input  logic [43:0] i_vtxX,
  input  logic [43:0] i_vtxY,
  input  logic [95:0] i_vtxRGB,
  input  logic [63:0] i_vtxUV,
  input  logic [15:0] i_clut,
  input  logic [15:0] i_tpage,
  input  logic [9:0]  i_width,
  input  logic [8:0]  i_height,
  output logic        o_validData,
  output logic [31:0] o_data,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_COL  = 3'd2,
    ST_XY   = 3'd3,
    ST_UV   = 3'd4,
    ST_SIZE = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  vcnt_q, vcnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [43:0] x_q, x_d, y_q, y_d;
  logic [95:0] rgb_q, rgb_d;
  logic [63:0] uv_q, uv_d;
  logic [15:0] clut_q, clut_d, tpage_q, tpage_d;
  logic [9:0]  w_q, w_d;
  logic [8:0]  h_q, h_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept, xfer, vertex_end;
  logic        is_poly, is_rect, is_fill, supported;
  logic        gouraud, quad, tex;
  logic [1:0]  rsize, last_v;
  logic [10:0] x_sel, y_sel;
  logic [23:0] rgb_sel;
  logic [15:0] uv_sel;

  assign accept = i_start & (state_q == ST_IDLE);
  assign xfer   = valid_q & i_ready;

  // Fields are only replaced on an accepted start, so they stay frozen mid-packet.
  always_comb begin
    if (accept) begin
      cmd_d = i_command;  x_d = i_vtxX;  y_d = i_vtxY;  rgb_d = i_vtxRGB;
      uv_d = i_vtxUV;  clut_d = i_clut;  tpage_d = i_tpage;
      w_d = i_width;  h_d = i_height;
    end else begin
      cmd_d = cmd_q;  x_d = x_q;  y_d = y_q;  rgb_d = rgb_q;
      uv_d = uv_q;  clut_d = clut_q;  tpage_d = tpage_q;
      w_d = w_q;  h_d = h_q;
    end
  end

  assign is_poly   = (cmd_d[7:5] == 3'b001);
  assign is_rect   = (cmd_d[7:5] == 3'b011);
  assign is_fill   = (cmd_d == 8'h02);
  assign supported = is_poly | is_rect | is_fill;
  assign gouraud   = cmd_d[4];
  assign quad      = cmd_d[3];
  assign tex       = cmd_d[2];
  assign rsize     = cmd_d[4:3];
  assign last_v    = quad ? 2'd3 : 2'd2;

  // Next-state: walk the word sequence, advancing only on a transfer.
  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    vertex_end = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          vcnt_d = 2'd0;
          if (supported) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD:  state_d = xfer ? ST_XY : ST_CMD;
      ST_COL:  state_d = xfer ? ST_XY : ST_COL;
      ST_XY: begin
        if (xfer) begin
          if (tex & ~is_fill) begin
            state_d = ST_UV;
          end else begin
            vertex_end = 1'b1;
          end
        end else begin
          state_d = ST_XY;
        end
      end
      ST_UV: begin
        if (xfer) begin
          vertex_end = 1'b1;
        end else begin
          state_d = ST_UV;
        end
      end
      ST_SIZE: state_d = xfer ? ST_DONE : ST_SIZE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (vertex_end) begin
      if (is_poly) begin
        if (vcnt_q == last_v) begin
          state_d = ST_DONE;
        end else begin
          vcnt_d  = vcnt_q + 2'd1;
          state_d = gouraud ? ST_COL : ST_XY;
        end
      end else if (is_rect) begin
        state_d = (rsize == 2'd0) ? ST_SIZE : ST_DONE;
      end else if (is_fill) begin
        state_d = ST_SIZE;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      vcnt_d = vcnt_d;
    end
  end

  // Output word for the state being entered, so o_data is a plain register.
  always_comb begin
    x_sel   = x_d[int'(vcnt_d) * 11 +: 11];
    y_sel   = y_d[int'(vcnt_d) * 11 +: 11];
    rgb_sel = rgb_d[int'(vcnt_d) * 24 +: 24];
    uv_sel  = uv_d[int'(vcnt_d) * 16 +: 16];
    data_d  = 32'h0000_0000;
    case (state_d)
      ST_CMD:  data_d = {cmd_d, rgb_d[23:0]};
      ST_COL:  data_d = {8'h00, rgb_sel};
      ST_XY:   data_d = {5'd0, y_sel, 5'd0, x_sel};
      ST_UV: begin
        case (vcnt_d)
          2'd0:    data_d = {clut_d, uv_sel};
          2'd1:    data_d = {tpage_d, uv_sel};
          default: data_d = {16'h0000, uv_sel};
        endcase
      end
      ST_SIZE: data_d = {7'd0, h_d, 6'd0, w_d};
      default: data_d = 32'h0000_0000;
    endcase
    valid_d = (state_d == ST_CMD) | (state_d == ST_COL) | (state_d == ST_XY) |
              (state_d == ST_UV) | (state_d == ST_SIZE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;  vcnt_q <= 2'd0;
      cmd_q <= 8'h00;  x_q <= 44'h0;  y_q <= 44'h0;  rgb_q <= 96'h0;
      uv_q <= 64'h0;  clut_q <= 16'h0;  tpage_q <= 16'h0;
      w_q <= 10'h0;  h_q <= 9'h0;
      valid_q <= 1'b0;  data_q <= 32'h0;  busy_q <= 1'b0;
      done_q <= 1'b0;  error_q <= 1'b0;
    end else begin
      state_q <= state_d;  vcnt_q <= vcnt_d;
      cmd_q <= cmd_d;  x_q <= x_d;  y_q <= y_d;  rgb_q <= rgb_d;
      uv_q <= uv_d;  clut_q <= clut_d;  tpage_q <= tpage_d;
      w_q <= w_d;  h_q <= h_d;
      valid_q <= valid_d;  data_q <= data_d;  busy_q <= busy_d;
      done_q <= done_d;  error_q <= error_d;
    end
  end

  assign o_validData = valid_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_gpu_cmd_packet_writer.sv
// Directed bench for gpu_cmd_packet_writer with hand-computed GP0 word streams.
module tb_gpu_cmd_packet_writer;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_command = 8'h00;
  logic [43:0] i_vtxX = 44'h0;
  logic [43:0] i_vtxY = 44'h0;
  logic [95:0] i_vtxRGB = 96'h0;
  logic [63:0] i_vtxUV = 64'h0;
  logic [15:0] i_clut = 16'h0;
  logic [15:0] i_tpage = 16'h0;
  logic [9:0]  i_width = 10'h0;
  logic [8:0]  i_height = 9'h0;
  logic        i_ready = 1'b0;
  logic        o_validData, o_busy, o_done, o_error;
  logic [31:0] o_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  gpu_cmd_packet_writer dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_command(i_command),
    .i_vtxX(i_vtxX), .i_vtxY(i_vtxY), .i_vtxRGB(i_vtxRGB), .i_vtxUV(i_vtxUV),
    .i_clut(i_clut), .i_tpage(i_tpage), .i_width(i_width), .i_height(i_height),
    .o_validData(o_validData), .o_data(o_data), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Starts a packet and drains it against exp_q; bp adds random stalls and a
  // mid-packet start, start_at_done pulses i_start while o_done is high.
  task automatic run_pkt(input string tag, input bit bp, input bit start_at_done);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held = 32'h0;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, o_busy}, 32'd1);
    chk({tag, "_valid_rise"}, {31'd0, o_validData}, 32'd1);
    while (got < exp_q.size() && cyc < 400) begin
      i_ready = bp ? (($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0) : 1'b1;
      if (bp && cyc == 3) begin
        i_start   = 1'b1;
        i_command = 8'h20;
        i_vtxX    = 44'h0;
      end
      if (o_validData) begin
        if (stalled) chk({tag, "_stable"}, o_data, held);
        if (i_ready) begin
          chk($sformatf("%s_word%0d", tag, got), o_data, exp_q[got]);
          got++;
          stalled = 1'b0;
        end else begin
          held    = o_data;
          stalled = 1'b1;
        end
      end
      cyc++;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_ready = 1'b0;
    chk({tag, "_all_words"}, got, exp_q.size());
    if (!bp) chk({tag, "_no_bubbles"}, cyc, exp_q.size());
    chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd1);
    chk({tag, "_valid_at_done"}, {31'd0, o_validData}, 32'd0);
    if (start_at_done) begin
      i_command = 8'h68;
      i_start   = 1'b1;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_done_clear"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_busy_clear"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_valid_idle"}, {31'd0, o_validData}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {31'd0, o_validData}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // 0x20 flat triangle
    i_command = 8'h20;
    i_vtxX    = {11'd0, 11'h7FB, 11'd30, 11'd10};
    i_vtxY    = {11'd0, 11'd7, 11'd40, 11'd20};
    i_vtxRGB  = {72'h0, 24'hFF0080};
    exp_q = '{32'h20FF0080, 32'h0014000A, 32'h0028001E, 32'h000707FB};
    run_pkt("tri20", 1'b0, 1'b0);

    // 0x3C gouraud textured quad, then the same under backpressure
    i_command = 8'h3C;
    i_vtxX    = {11'd4, 11'd3, 11'd2, 11'd1};
    i_vtxY    = {11'd8, 11'd7, 11'd6, 11'd5};
    i_vtxRGB  = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};
    i_vtxUV   = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
    i_clut    = 16'hC1C1;
    i_tpage   = 16'h7A7A;
    exp_q = '{32'h3C112233, 32'h00050001, 32'hC1C10101, 32'h00445566,
              32'h00060002, 32'h7A7A0202, 32'h00778899, 32'h00070003,
              32'h00000303, 32'h00AABBCC, 32'h00080004, 32'h00000404};
    run_pkt("quad3c", 1'b0, 1'b0);
    run_pkt("quad3c_bp", 1'b1, 1'b0);

    // 0x64 textured variable-size rect; start during o_done is ignored
    i_command = 8'h64;
    i_vtxX    = {33'd0, 11'd10};
    i_vtxY    = {33'd0, 11'd20};
    i_vtxRGB  = {72'h0, 24'h445566};
    i_vtxUV   = {48'h0, 16'h3412};
    i_clut    = 16'hABCD;
    i_width   = 10'd100;
    i_height  = 9'd50;
    exp_q = '{32'h64445566, 32'h0014000A, 32'hABCD3412, 32'h00320064};
    run_pkt("rect64", 1'b0, 1'b1);
    @(negedge i_clk);
    chk("ignored_start_valid", {31'd0, o_validData}, 32'd0);
    chk("ignored_start_busy", {31'd0, o_busy}, 32'd0);

    // 0x68 1x1 sprite
    i_command = 8'h68;
    exp_q = '{32'h68445566, 32'h0014000A};
    run_pkt("rect68", 1'b0, 1'b0);

    // 0x02 fill
    i_command = 8'h02;
    i_width   = 10'h3F0;
    i_height  = 9'h1FF;
    exp_q = '{32'h02445566, 32'h0014000A, 32'h01FF03F0};
    run_pkt("fill02", 1'b0, 1'b0);

    // 0xE1 unsupported: error pulse, no words
    i_command = 8'hE1;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_ready = 1'b1;
    chk("err_pulse", {31'd0, o_error}, 32'd1);
    chk("err_busy", {31'd0, o_busy}, 32'd0);
    chk("err_valid", {31'd0, o_validData}, 32'd0);
    @(negedge i_clk);
    chk("err_clear", {31'd0, o_error}, 32'd0);
    chk("err_no_words", {31'd0, o_validData}, 32'd0);
    i_ready = 1'b0;

    // Reset during a stalled packet
    i_command = 8'h3C;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("stall_valid", {31'd0, o_validData}, 32'd1);
    i_nrst = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, o_validData}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    i_command = 8'h68;
    i_width   = 10'd100;
    i_height  = 9'd50;
    exp_q = '{32'h68445566, 32'h0014000A};
    run_pkt("after_rst", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
